// File: rtl/sub_32_pipe_if.sv
// Operand/result handshake bundle for sub_32_pipe.
// Optional macro SUB_32_PIPE_ADDSUB_EN adds the per-beat op_add select.
interface sub_32_pipe_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
`ifdef SUB_32_PIPE_ADDSUB_EN
    logic             op_add;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             b_out;
    logic             ovf;
    logic             zero;

`ifdef SUB_32_PIPE_ADDSUB_EN
    modport slave (
        input  in_valid, a, b, b_in, op_add, out_ready,
        output in_ready, out_valid, diff, b_out, ovf, zero
    );
    modport master (
        output in_valid, a, b, b_in, op_add, out_ready,
        input  in_ready, out_valid, diff, b_out, ovf, zero
    );
`else
    modport slave (
        input  in_valid, a, b, b_in, out_ready,
        output in_ready, out_valid, diff, b_out, ovf, zero
    );
    modport master (
        output in_valid, a, b, b_in, out_ready,
        input  in_ready, out_valid, diff, b_out, ovf, zero
    );
`endif
endinterface

// File: rtl/sub_32_pipe.sv
// Two-stage pipelined subtractor (a - b - b_in) with group-lookahead borrow.
// Stage 1 resolves the low half, stage 2 the high half and the flags.
// Optional macro SUB_32_PIPE_ADDSUB_EN: per-beat op_add selects a + b + b_in.
module sub_32_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned GROUP = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    sub_32_pipe_if.slave  bus
);
    localparam int unsigned HALF = WIDTH / 2;
    localparam int unsigned NGRP = HALF / GROUP;

    // Half-width subtract: returns {borrow_out, diff}; group borrows skip ahead
    function automatic logic [HALF:0] sub_half(
        input logic [HALF-1:0] x,
        input logic [HALF-1:0] y,
        input logic            bi
    );
        logic [HALF-1:0] p;
        logic [HALF-1:0] g;
        logic [HALF-1:0] d;
        logic [NGRP:0]   gb;
        logic            gg;
        logic            gp;
        logic            c;
        p     = ~(x ^ y);
        g     = ~x & y;
        d     = '0;
        gb    = '0;
        gb[0] = bi;
        for (int k = 0; k < int'(NGRP); k++) begin
            gg = 1'b0;
            gp = 1'b1;
            for (int j = 0; j < int'(GROUP); j++) begin
                gg = g[k*GROUP+j] | (p[k*GROUP+j] & gg);
                gp = gp & p[k*GROUP+j];
            end
            gb[k+1] = gg | (gp & gb[k]);
        end
        for (int k = 0; k < int'(NGRP); k++) begin
            c = gb[k];
            for (int j = 0; j < int'(GROUP); j++) begin
                d[k*GROUP+j] = x[k*GROUP+j] ^ y[k*GROUP+j] ^ c;
                c = g[k*GROUP+j] | (p[k*GROUP+j] & c);
            end
        end
        return {gb[NGRP], d};
    endfunction

    logic             v1;
    logic             v2;
    logic             adv1;
    logic             adv2;
    logic             op_c;
    logic [WIDTH-1:0] b_eff_c;
    logic             bin_eff_c;
    logic [HALF:0]    lo_c;
    logic [HALF:0]    hi_c;
    logic [WIDTH-1:0] diff_c;

    logic [HALF-1:0]  s1_dlo;
    logic             s1_borrow;
    logic [HALF-1:0]  s1_ahi;
    logic [HALF-1:0]  s1_bhi;
    logic             s1_op;

    logic [WIDTH-1:0] res_diff;
    logic             res_b_out;
    logic             res_ovf;
    logic             res_zero;

`ifdef SUB_32_PIPE_ADDSUB_EN
    assign op_c = bus.op_add;
`else
    assign op_c = 1'b0;
`endif

    // Handshake: a stage moves when its successor frees up this cycle
    assign adv2         = !v2 || bus.out_ready;
    assign adv1         = !v1 || adv2;
    assign bus.in_ready = adv1;

    // Add is a + b + c == a - ~b - ~c, with carry out == ~borrow out
    always_comb begin
        b_eff_c   = op_c ? ~bus.b : bus.b;
        bin_eff_c = op_c ? ~bus.b_in : bus.b_in;
        lo_c      = sub_half(bus.a[HALF-1:0], b_eff_c[HALF-1:0], bin_eff_c);
        hi_c      = sub_half(s1_ahi, s1_bhi, s1_borrow);
        diff_c    = {hi_c[HALF-1:0], s1_dlo};
    end

    // Stage 1: low half result, inter-half borrow, high-half operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            s1_dlo    <= '0;
            s1_borrow <= 1'b0;
            s1_ahi    <= '0;
            s1_bhi    <= '0;
            s1_op     <= 1'b0;
        end else if (adv1) begin
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
                s1_dlo    <= lo_c[HALF-1:0];
                s1_borrow <= lo_c[HALF];
                s1_ahi    <= bus.a[WIDTH-1:HALF];
                s1_bhi    <= b_eff_c[WIDTH-1:HALF];
                s1_op     <= op_c;
            end
        end
    end

    // Stage 2: high half and flags; only valid stage-1 data is loaded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2        <= 1'b0;
            res_diff  <= '0;
            res_b_out <= 1'b0;
            res_ovf   <= 1'b0;
            res_zero  <= 1'b0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                res_diff  <= diff_c;
                res_b_out <= hi_c[HALF] ^ s1_op;
                res_ovf   <= (s1_ahi[HALF-1] != s1_bhi[HALF-1]) &&
                             (hi_c[HALF-1] != s1_ahi[HALF-1]);
                res_zero  <= (diff_c == '0);
            end
        end
    end

    assign bus.out_valid = v2;
    assign bus.diff      = res_diff;
    assign bus.b_out     = res_b_out;
    assign bus.ovf       = res_ovf;
    assign bus.zero      = res_zero;

endmodule

// File: tb/tb_sub_32_pipe.sv
// Self-checking bench for sub_32_pipe: directed cases plus randomized
// handshake traffic scored against an arithmetic reference model.
module tb_sub_32_pipe;

    typedef struct packed {
        logic [31:0] diff;
        logic        bo;
        logic        ovf;
        logic        zero;
    } res_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic cur_op;
    logic stalled;
    logic [31:0] held_diff;
    res_t exp_q[$];

    sub_32_pipe_if #(.WIDTH(32)) bus_i ();

    sub_32_pipe #(.WIDTH(32), .GROUP(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always terminates
    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain wide arithmetic on the operands
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic bin, input logic add);
        logic [32:0] full;
        res_t r;
        if (add) full = {1'b0, a} + {1'b0, b} + 33'(bin);
        else     full = {1'b0, a} - {1'b0, b} - 33'(bin);
        r.diff = full[31:0];
        r.bo   = full[32];
        if (add) r.ovf = (a[31] == b[31]) && (r.diff[31] != a[31]);
        else     r.ovf = (a[31] != b[31]) && (r.diff[31] != a[31]);
        r.zero = (r.diff == 32'd0);
        return r;
    endfunction

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic bin, input logic add);
        bus_i.in_valid = v;
        bus_i.a        = a;
        bus_i.b        = b;
        bus_i.b_in     = bin;
`ifdef SUB_32_PIPE_ADDSUB_EN
        bus_i.op_add   = add;
        cur_op         = add;
`else
        cur_op         = 1'b0;
`endif
    endtask

    // One cycle: sample at negedge, score outputs, record input transfer
    task automatic step(output logic fired);
        res_t e;
        @(negedge clk);
        if (stalled) begin
            check("hold_valid", 32'(bus_i.out_valid), 32'd1);
            check("hold_diff", bus_i.diff, held_diff);
        end
        if (bus_i.out_valid && bus_i.out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 32'(bus_i.out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("diff", bus_i.diff, e.diff);
                check("b_out", 32'(bus_i.b_out), 32'(e.bo));
                check("ovf", 32'(bus_i.ovf), 32'(e.ovf));
                check("zero", 32'(bus_i.zero), 32'(e.zero));
            end
        end
        stalled   = bus_i.out_valid && !bus_i.out_ready;
        held_diff = bus_i.diff;
        fired     = bus_i.in_valid && bus_i.in_ready;
        if (fired) exp_q.push_back(model(bus_i.a, bus_i.b, bus_i.b_in, cur_op));
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic bin, input logic add);
        logic f;
        f = 1'b0;
        drive(1'b1, a, b, bin, add);
        for (int i = 0; i < 20 && !f; i++) step(f);
        if (!f) check("send_timeout", 32'(bus_i.in_ready), 32'd1);
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h0000_FFFF + 32'($urandom_range(0, 2));
            default: return $urandom;
        endcase
    endfunction

    logic        f;
    logic [31:0] da[5];
    logic [31:0] db[5];
    logic        dbin[5];
    logic        pend;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rbin;
    logic        rop;

    initial begin
        total   = 0;
        bad     = 0;
        stalled = 1'b0;
        held_diff = 32'd0;
        cur_op  = 1'b0;
        rst_n   = 1'b0;
        bus_i.out_ready = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

        // Reset state
        #3;
        check("rst_out_valid", 32'(bus_i.out_valid), 32'd0);
        check("rst_diff", bus_i.diff, 32'd0);
        check("rst_b_out", 32'(bus_i.b_out), 32'd0);
        check("rst_ovf", 32'(bus_i.ovf), 32'd0);
        check("rst_zero", 32'(bus_i.zero), 32'd0);
        check("rst_in_ready", 32'(bus_i.in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic subtract and two-cycle latency
        bus_i.out_ready = 1'b1;
        drive(1'b1, 32'd5, 32'd3, 1'b0, 1'b0);
        step(f);
        check("basic_accept", 32'(f), 32'd1);
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        check("lat1_valid", 32'(bus_i.out_valid), 32'd0);
        step(f);
        check("lat2_valid", 32'(bus_i.out_valid), 32'd1);
        check("basic_diff", bus_i.diff, 32'd2);
        check("basic_b_out", 32'(bus_i.b_out), 32'd0);
        check("basic_ovf", 32'(bus_i.ovf), 32'd0);
        check("basic_zero", 32'(bus_i.zero), 32'd0);
        step(f);

        // Cross-half borrow, underflow, overflow, zero
        da[0] = 32'h0001_0000; db[0] = 32'd1; dbin[0] = 1'b0;
        da[1] = 32'd1;         db[1] = 32'd2; dbin[1] = 1'b0;
        da[2] = 32'h8000_0000; db[2] = 32'd1; dbin[2] = 1'b0;
        da[3] = 32'd7;         db[3] = 32'd7; dbin[3] = 1'b0;
        da[4] = 32'd7;         db[4] = 32'd7; dbin[4] = 1'b1;
        for (int i = 0; i < 5; i++) send(da[i], db[i], dbin[i], 1'b0);
        for (int i = 0; i < 3; i++) step(f);
        check("directed_drained", 32'(exp_q.size()), 32'd0);

        // Backpressure: two beats fill the pipe, third is held off
        bus_i.out_ready = 1'b0;
        drive(1'b1, 32'd10, 32'd1, 1'b0, 1'b0);
        step(f);
        check("bp_acc1", 32'(f), 32'd1);
        drive(1'b1, 32'd20, 32'd2, 1'b0, 1'b0);
        step(f);
        check("bp_acc2", 32'(f), 32'd1);
        drive(1'b1, 32'd30, 32'd3, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(f);
            check("bp_blocked", 32'(f), 32'd0);
        end
        check("bp_held_diff", bus_i.diff, 32'd9);
        bus_i.out_ready = 1'b1;
        check("bp_stream0", 32'(bus_i.out_valid), 32'd1);
        step(f);
        check("bp_acc3", 32'(f), 32'd1);
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        check("bp_stream1", 32'(bus_i.out_valid), 32'd1);
        check("bp_diff18", bus_i.diff, 32'd18);
        step(f);
        check("bp_stream2", 32'(bus_i.out_valid), 32'd1);
        check("bp_diff27", bus_i.diff, 32'd27);
        step(f);
        step(f);
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // Reset mid-flight discards in-flight beats
        bus_i.out_ready = 1'b0;
        send(32'd100, 32'd1, 1'b0, 1'b0);
        send(32'd200, 32'd2, 1'b0, 1'b0);
        check("mid_full_in_ready", 32'(bus_i.in_ready), 32'd0);
        rst_n = 1'b0;
        #2;
        check("mid_out_valid", 32'(bus_i.out_valid), 32'd0);
        check("mid_diff", bus_i.diff, 32'd0);
        check("mid_b_out", 32'(bus_i.b_out), 32'd0);
        check("mid_ovf", 32'(bus_i.ovf), 32'd0);
        check("mid_zero", 32'(bus_i.zero), 32'd0);
        exp_q.delete();
        stalled = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_in_ready", 32'(bus_i.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus_i.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("mid_no_stale", 32'(bus_i.out_valid), 32'd0);
            step(f);
        end

`ifdef SUB_32_PIPE_ADDSUB_EN
        // Mixed add/subtract stream
        drive(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
        step(f);
        check("mix_acc_add", 32'(f), 32'd1);
        drive(1'b1, 32'd5, 32'd3, 1'b0, 1'b0);
        step(f);
        check("mix_acc_sub", 32'(f), 32'd1);
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        check("mix_add_diff", bus_i.diff, 32'd0);
        check("mix_add_carry", 32'(bus_i.b_out), 32'd1);
        check("mix_add_zero", 32'(bus_i.zero), 32'd1);
        step(f);
        check("mix_sub_valid", 32'(bus_i.out_valid), 32'd1);
        check("mix_sub_diff", bus_i.diff, 32'd2);
        step(f);
`endif

        // Randomized traffic with random backpressure
        pend = 1'b0;
        ra = 32'd0; rb = 32'd0; rbin = 1'b0; rop = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            if (!pend && ($urandom_range(0, 9) < 6)) begin
                pend = 1'b1;
                ra   = pick();
                rb   = pick();
                rbin = 1'($urandom_range(0, 1));
                rop  = 1'($urandom_range(0, 1));
            end
            drive(pend, ra, rb, rbin, rop);
            bus_i.out_ready = ($urandom_range(0, 9) < 7);
            step(f);
            if (f) pend = 1'b0;
        end
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        bus_i.out_ready = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) step(f);
        check("rand_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sub_32_pipe.md
Name: sub_32_pipe

Overview:
- Two-stage pipelined 32-bit subtractor computing a - b - b_in with group-lookahead borrow logic. It is the inverse-operation companion of add_32_bit.
- Stage 1 resolves the low half and registers the high-half operands together with the inter-half borrow. Stage 2 resolves the high half and registers the result.
- Valid/ready handshake on both sides, so it drops into the datapath between an operand source and a result consumer.

Parameters:
- WIDTH, 32, operand/result width; must be even. The low half is bits [WIDTH/2-1:0].
- GROUP, 4, lookahead group width in bits; must divide WIDTH/2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat present
- in_ready  output  1  block can accept an operand beat this cycle
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- b_in  input  1  borrow in
- out_valid  output  1  result beat present
- out_ready  input  1  consumer accepts the result this cycle
- diff  output  WIDTH  a - b - b_in, modulo 2^WIDTH
- b_out  output  1  borrow out: 1 iff unsigned a < b + b_in
- ovf  output  1  signed overflow: (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB])
- zero  output  1  diff == 0

Behaviour:
- Reset (async assert, sync-safe deassert): stage valids v1 = v2 = 0. out_valid, diff, b_out, ovf and zero all read 0. Any in-flight beats are discarded, never emitted.
- Transfers:
  - Input transfer on a clk edge with in_valid && in_ready.
  - Output transfer on a clk edge with out_valid && out_ready.
- Stage acceptance:
  - adv2 = !v2 || out_ready. adv1 = !v1 || adv2.
  - in_ready = adv1. This is a combinational path from out_ready; no skid buffer.
- Stage 1 on adv1:
  - Loads low-half diff, low-half borrow (group lookahead, borrow-propagate = ~(a^b), borrow-generate = ~a & b), a/b high halves and MSB signs.
  - v1 <= in_valid.
- Stage 2 on adv2:
  - Computes the high half using the stage-1 borrow as its borrow-in, then registers diff, b_out, ovf and zero.
  - v2 <= v1.
- Holding: when a stage does not advance, its registers hold. Output data is stable while out_valid && !out_ready.
- Latency: 2 cycles from input transfer to out_valid when unstalled. Throughput is 1 beat/cycle.
- Ordering: results leave in acceptance order; no loss, no duplication.
- Capacity: 2 beats. With out_ready = 0 and both stages full, in_ready = 0.
- Simultaneous output transfer and input transfer in the same cycle is legal and keeps full throughput.
- Data when v1 = 0: stage-1 data is don't-care but must not propagate to outputs.
- Reset during a stall: the pipe empties immediately, and in_ready = 1 in the first cycle after rst_n rises.

Optional Feature:
- Macro: SUB_32_PIPE_ADDSUB_EN.
- Defined:
  - Adds input port op_add (1 bit), captured with the operands.
  - op_add = 1 computes a + b + b_in, b_out carries carry-out, and ovf uses the add rule (a[MSB] == b[MSB]) && (diff[MSB] != a[MSB]).
  - op_add = 0 gives the subtract behaviour above.
  - Operation is selected per beat, so mixed streams are allowed.
- Undefined: port absent; the block only subtracts.

Test Plan:
- Basic subtract: a=5, b=3, b_in=0, out_ready=1 -> exactly 2 cycles later out_valid=1, diff=0x00000002, b_out=0, ovf=0, zero=0.
- Cross-half borrow and underflow:
  - a=0x00010000, b=1 -> diff=0x0000FFFF, b_out=0.
  - a=1, b=2 -> diff=0xFFFFFFFF, b_out=1, ovf=0.
- Overflow and zero:
  - a=0x80000000, b=1 -> diff=0x7FFFFFFF, ovf=1, b_out=0.
  - a=7, b=7, b_in=0 -> zero=1.
  - a=7, b=7, b_in=1 -> diff=0xFFFFFFFF, b_out=1, zero=0.
- Backpressure: out_ready=0, drive beats 10-1, 20-2, 30-3 back-to-back -> first two accepted, in_ready=0 on the third, diff stable. Raise out_ready -> 9, 18, 27 emitted in order, one per cycle, no duplicates.
- Reset mid-flight: two beats in pipe, pulse rst_n low between clk edges -> out_valid=0 and all outputs 0 immediately. After release, in_ready=1 and no stale beat appears.
- With SUB_32_PIPE_ADDSUB_EN: alternate op_add=1 (0xFFFFFFFF + 1 -> diff=0, b_out=1, zero=1) and op_add=0 (5 - 3 -> 2) in consecutive cycles -> both correct, in order.
